// File: rtl/memc_pkg.sv
// Shared definitions for the memory-controller port arbiter: ownership FSM
// states, default bus widths and the round-robin helper.
package memc_pkg;

  localparam int MEMC_ADDR_W = 24;
  localparam int MEMC_DATA_W = 32;

  // Round-robin pointer encoding: which DMA port wins the next contested cycle.
  localparam logic RR_PICK_WRITE = 1'b0;
  localparam logic RR_PICK_READ  = 1'b1;

  typedef enum logic [1:0] {
    DMA_OWN  = 2'd0,
    DRAIN    = 2'd1,
    LDST_OWN = 2'd2,
    RELEASE  = 2'd3
  } memc_state_e;

  // Both DMA ports want the single SRAM slot in the same cycle.
  function automatic logic rr_contested(input logic wr_req, input logic rd_req);
    return wr_req & rd_req;
  endfunction

endpackage

// File: rtl/memc_port_arbiter_if.sv
// Bus bundle between the arbiter, its DMA and SIMD load/store clients and the SRAM.
interface memc_port_arbiter_if #(
  parameter int ADDR_W = memc_pkg::MEMC_ADDR_W,
  parameter int DATA_W = memc_pkg::MEMC_DATA_W
) ();

  logic              dma__memc__write_valid;
  logic [ADDR_W-1:0] dma__memc__write_address;
  logic [DATA_W-1:0] dma__memc__write_data;
  logic              memc__dma__write_ready;

  logic              dma__memc__read_valid;
  logic [ADDR_W-1:0] dma__memc__read_address;
  logic              dma__memc__read_pause;
  logic              memc__dma__read_ready;
  logic [DATA_W-1:0] memc__dma__read_data;
  logic              memc__dma__read_data_valid;

  logic              ldst__memc__request;
  logic              ldst__memc__released;
  logic              memc__ldst__granted;
  logic              ldst__memc__valid;
  logic              ldst__memc__we;
  logic [ADDR_W-1:0] ldst__memc__address;
  logic [DATA_W-1:0] ldst__memc__write_data;
  logic [DATA_W-1:0] memc__ldst__read_data;
  logic              memc__ldst__read_data_valid;

  logic              memc__mem__en;
  logic              memc__mem__we;
  logic [ADDR_W-1:0] memc__mem__address;
  logic [DATA_W-1:0] memc__mem__write_data;
  logic [DATA_W-1:0] mem__memc__read_data;

  modport slave (
    input  dma__memc__write_valid, dma__memc__write_address, dma__memc__write_data,
    output memc__dma__write_ready,
    input  dma__memc__read_valid, dma__memc__read_address, dma__memc__read_pause,
    output memc__dma__read_ready, memc__dma__read_data, memc__dma__read_data_valid,
    input  ldst__memc__request, ldst__memc__released,
    output memc__ldst__granted,
    input  ldst__memc__valid, ldst__memc__we, ldst__memc__address, ldst__memc__write_data,
    output memc__ldst__read_data, memc__ldst__read_data_valid,
    output memc__mem__en, memc__mem__we, memc__mem__address, memc__mem__write_data,
    input  mem__memc__read_data
  );

  modport master (
    output dma__memc__write_valid, dma__memc__write_address, dma__memc__write_data,
    input  memc__dma__write_ready,
    output dma__memc__read_valid, dma__memc__read_address, dma__memc__read_pause,
    input  memc__dma__read_ready, memc__dma__read_data, memc__dma__read_data_valid,
    output ldst__memc__request, ldst__memc__released,
    input  memc__ldst__granted,
    output ldst__memc__valid, ldst__memc__we, ldst__memc__address, ldst__memc__write_data,
    input  memc__ldst__read_data, memc__ldst__read_data_valid,
    input  memc__mem__en, memc__mem__we, memc__mem__address, memc__mem__write_data,
    output mem__memc__read_data
  );

endinterface

// File: rtl/memc_rr_pick2.sv
// Chooses between the DMA write and read ports with a 1-bit round-robin pointer
// that advances only when both ports competed for the same cycle.
module memc_rr_pick2
  import memc_pkg::*;
(
  input  logic clk,
  input  logic reset_poweron,
  input  logic enable,
  input  logic wr_valid,
  input  logic rd_valid,
  input  logic rd_pause,
  output logic wr_ready,
  output logic rd_ready
);

  logic ptr_r;
  logic rd_req_s;
  logic contested_s;

  // Ready generation: uncontested ports stay ready, contested ones follow the pointer.
  always_comb begin
    rd_req_s    = rd_valid & ~rd_pause;
    contested_s = rr_contested(wr_valid, rd_req_s);
    if (enable) begin
      wr_ready = ~(contested_s & (ptr_r == RR_PICK_READ));
      rd_ready = ~rd_pause & ~(contested_s & (ptr_r == RR_PICK_WRITE));
    end else begin
      wr_ready = 1'b0;
      rd_ready = 1'b0;
    end
  end

  // Pointer update after a contested grant.
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      ptr_r <= RR_PICK_WRITE;
    end else if (enable && contested_s) begin
      ptr_r <= ~ptr_r;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/memc_port_arbiter.sv
// Single-port SRAM arbiter: the DMA engine owns the SRAM by default; the SIMD
// load/store unit takes exclusive ownership via a request/grant/release handshake.
module memc_port_arbiter
  import memc_pkg::*;
#(
  parameter int ADDR_W = MEMC_ADDR_W,
  parameter int DATA_W = MEMC_DATA_W
) (
  input logic                clk,
  input logic                reset_poweron,
  memc_port_arbiter_if.slave bus
);

  memc_state_e       state_r;
  memc_state_e       state_s;
  logic              go_drain_s;
  logic              arb_en_s;
  logic              wr_ready_s;
  logic              rd_ready_s;
  logic              dma_wr_fire_s;
  logic              dma_rd_fire_s;
  logic              ldst_fire_s;
  logic              dma_rd_inflight_r;
  logic              ldst_rd_inflight_r;
  logic              req_pending_r;
  logic              mem_en_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_s;

  // Next-state logic; a request latched during RELEASE counts as a request here.
  always_comb begin
    state_s    = state_r;
    go_drain_s = 1'b0;
    case (state_r)
      DMA_OWN: begin
        go_drain_s = bus.ldst__memc__request | req_pending_r;
        if (go_drain_s) begin
          state_s = DRAIN;
        end else begin
          state_s = DMA_OWN;
        end
      end
      DRAIN:    state_s = LDST_OWN;
      LDST_OWN: begin
        if (bus.ldst__memc__released) begin
          state_s = RELEASE;
        end else begin
          state_s = LDST_OWN;
        end
      end
      RELEASE:  state_s = DMA_OWN;
      default:  state_s = DMA_OWN;
    endcase
  end

  assign arb_en_s = (state_r == DMA_OWN) & ~go_drain_s & ~reset_poweron;

  memc_rr_pick2 u_rr_pick2 (
    .clk           (clk),
    .reset_poweron (reset_poweron),
    .enable        (arb_en_s),
    .wr_valid      (bus.dma__memc__write_valid),
    .rd_valid      (bus.dma__memc__read_valid),
    .rd_pause      (bus.dma__memc__read_pause),
    .wr_ready      (wr_ready_s),
    .rd_ready      (rd_ready_s)
  );

  // Accepted-access decode and SRAM command mux (at most one source fires).
  always_comb begin
    dma_wr_fire_s = wr_ready_s & bus.dma__memc__write_valid;
    dma_rd_fire_s = rd_ready_s & bus.dma__memc__read_valid;
    ldst_fire_s   = (state_r == LDST_OWN) & bus.ldst__memc__valid & ~reset_poweron;
    mem_en_s      = 1'b0;
    mem_we_s      = 1'b0;
    mem_addr_s    = '0;
    mem_wdata_s   = '0;
    if (ldst_fire_s) begin
      mem_en_s    = 1'b1;
      mem_we_s    = bus.ldst__memc__we;
      mem_addr_s  = bus.ldst__memc__address;
      mem_wdata_s = bus.ldst__memc__write_data;
    end else if (dma_wr_fire_s) begin
      mem_en_s    = 1'b1;
      mem_we_s    = 1'b1;
      mem_addr_s  = bus.dma__memc__write_address;
      mem_wdata_s = bus.dma__memc__write_data;
    end else if (dma_rd_fire_s) begin
      mem_en_s    = 1'b1;
      mem_we_s    = 1'b0;
      mem_addr_s  = bus.dma__memc__read_address;
      mem_wdata_s = '0;
    end else begin
      mem_en_s    = 1'b0;
    end
  end

  // State, in-flight read tracking and pending-request capture.
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      state_r            <= DMA_OWN;
      dma_rd_inflight_r  <= 1'b0;
      ldst_rd_inflight_r <= 1'b0;
      req_pending_r      <= 1'b0;
    end else begin
      state_r            <= state_s;
      dma_rd_inflight_r  <= dma_rd_fire_s;
      ldst_rd_inflight_r <= ldst_fire_s & ~bus.ldst__memc__we;
      req_pending_r      <= (state_r == RELEASE) & bus.ldst__memc__request;
    end
  end

  // Reset gating keeps data_valid and grant quiet while reset is held.
  assign bus.memc__dma__write_ready      = wr_ready_s;
  assign bus.memc__dma__read_ready       = rd_ready_s;
  assign bus.memc__dma__read_data        = bus.mem__memc__read_data;
  assign bus.memc__dma__read_data_valid  = dma_rd_inflight_r & ~reset_poweron;
  assign bus.memc__ldst__granted         = (state_r == LDST_OWN) & ~reset_poweron;
  assign bus.memc__ldst__read_data       = bus.mem__memc__read_data;
  assign bus.memc__ldst__read_data_valid = ldst_rd_inflight_r & ~reset_poweron;
  assign bus.memc__mem__en               = mem_en_s;
  assign bus.memc__mem__we               = mem_we_s;
  assign bus.memc__mem__address          = mem_addr_s;
  assign bus.memc__mem__write_data       = mem_wdata_s;

endmodule

// File: tb/tb_memc_port_arbiter.sv
// Directed bench for memc_port_arbiter: a table of DMA arbitration cycles
// followed by hand-written ownership-handoff and reset sequences.
module tb_memc_port_arbiter;

  logic clk;
  logic reset_poweron;
  int   total;
  int   bad;

  memc_port_arbiter_if #(.ADDR_W(24), .DATA_W(32)) bus ();

  memc_port_arbiter #(.ADDR_W(24), .DATA_W(32)) dut (
    .clk           (clk),
    .reset_poweron (reset_poweron),
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM with one-cycle read latency
  logic [31:0] sram [0:255];
  always @(posedge clk) begin
    if (bus.memc__mem__en) begin
      if (bus.memc__mem__we) sram[bus.memc__mem__address[7:0]] <= bus.memc__mem__write_data;
      else bus.mem__memc__read_data <= sram[bus.memc__mem__address[7:0]];
    end
  end

  typedef struct packed {
    logic wv; logic rv; logic pause; logic req;
    logic wr_rdy; logic rd_rdy; logic en; logic we; logic rdv;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.dma__memc__write_valid   = 1'b0;
    bus.dma__memc__write_address = 24'h0;
    bus.dma__memc__write_data    = 32'h0;
    bus.dma__memc__read_valid    = 1'b0;
    bus.dma__memc__read_address  = 24'h0;
    bus.dma__memc__read_pause    = 1'b0;
    bus.ldst__memc__request      = 1'b0;
    bus.ldst__memc__released     = 1'b0;
    bus.ldst__memc__valid        = 1'b0;
    bus.ldst__memc__we           = 1'b0;
    bus.ldst__memc__address      = 24'h0;
    bus.ldst__memc__write_data   = 32'h0;
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    //              wv    rv    pse   req   wrdy  rrdy  en    we    rdv
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    idle();
    bus.mem__memc__read_data = 32'h0;
    reset_poweron = 1'b1;

    // Reset held with DMA traffic pending: nothing ready, nothing issued
    for (int r = 0; r < 2; r++) begin
      step();
      bus.dma__memc__write_valid = 1'b1;
      bus.dma__memc__read_valid  = 1'b1;
      #1;
      chk("rst_wr_ready", {31'h0, bus.memc__dma__write_ready}, 32'h0);
      chk("rst_rd_ready", {31'h0, bus.memc__dma__read_ready}, 32'h0);
      chk("rst_mem_en", {31'h0, bus.memc__mem__en}, 32'h0);
      chk("rst_granted", {31'h0, bus.memc__ldst__granted}, 32'h0);
    end

    // DMA arbitration table, starting in the first cycle out of reset
    for (int i = 0; i < 10; i++) begin
      step();
      reset_poweron                = 1'b0;
      bus.dma__memc__write_valid   = vecs[i].wv;
      bus.dma__memc__write_address = 24'h40 + 24'(i);
      bus.dma__memc__write_data    = 32'h100 + 32'(i);
      bus.dma__memc__read_valid    = vecs[i].rv;
      bus.dma__memc__read_address  = 24'h40 + 24'(i);
      bus.dma__memc__read_pause    = vecs[i].pause;
      bus.ldst__memc__request      = vecs[i].req;
      #1;
      chk($sformatf("v%0d_wr_ready", i), {31'h0, bus.memc__dma__write_ready}, {31'h0, vecs[i].wr_rdy});
      chk($sformatf("v%0d_rd_ready", i), {31'h0, bus.memc__dma__read_ready}, {31'h0, vecs[i].rd_rdy});
      chk($sformatf("v%0d_mem_en", i), {31'h0, bus.memc__mem__en}, {31'h0, vecs[i].en});
      chk($sformatf("v%0d_mem_we", i), {31'h0, bus.memc__mem__we}, {31'h0, vecs[i].we});
      chk($sformatf("v%0d_rd_dv", i), {31'h0, bus.memc__dma__read_data_valid}, {31'h0, vecs[i].rdv});
      chk($sformatf("v%0d_granted", i), {31'h0, bus.memc__ldst__granted}, 32'h0);
    end

    // DRAIN: request dropped, stray ldst access and DMA write ignored
    step();
    bus.ldst__memc__request    = 1'b0;
    bus.dma__memc__read_valid  = 1'b0;
    bus.ldst__memc__valid      = 1'b1;
    bus.ldst__memc__we         = 1'b1;
    bus.ldst__memc__address    = 24'h30;
    #1;
    chk("drain_granted", {31'h0, bus.memc__ldst__granted}, 32'h0);
    chk("drain_mem_en", {31'h0, bus.memc__mem__en}, 32'h0);
    chk("drain_wr_ready", {31'h0, bus.memc__dma__write_ready}, 32'h0);

    // LDST_OWN: write 0x20 = 0x1234, two cycles after the request
    step();
    bus.ldst__memc__address    = 24'h20;
    bus.ldst__memc__write_data = 32'h1234;
    #1;
    chk("ldst_granted", {31'h0, bus.memc__ldst__granted}, 32'h1);
    chk("ldst_wr_en", {31'h0, bus.memc__mem__en}, 32'h1);
    chk("ldst_wr_we", {31'h0, bus.memc__mem__we}, 32'h1);
    chk("ldst_wr_addr", {8'h0, bus.memc__mem__address}, 32'h20);
    chk("ldst_wr_data", bus.memc__mem__write_data, 32'h1234);
    chk("ldst_dma_wr_ready", {31'h0, bus.memc__dma__write_ready}, 32'h0);

    // Read 0x20 together with release
    step();
    bus.ldst__memc__we       = 1'b0;
    bus.ldst__memc__released = 1'b1;
    #1;
    chk("rel_rd_en", {31'h0, bus.memc__mem__en}, 32'h1);
    chk("rel_rd_we", {31'h0, bus.memc__mem__we}, 32'h0);

    // RELEASE: grant gone, read data returned
    step();
    bus.ldst__memc__valid    = 1'b0;
    bus.ldst__memc__released = 1'b0;
    #1;
    chk("release_granted", {31'h0, bus.memc__ldst__granted}, 32'h0);
    chk("release_ldst_dv", {31'h0, bus.memc__ldst__read_data_valid}, 32'h1);
    chk("release_ldst_data", bus.memc__ldst__read_data, 32'h1234);
    chk("release_wr_ready", {31'h0, bus.memc__dma__write_ready}, 32'h0);

    // Back in DMA_OWN two cycles after release: DMA write 0x10 = 0xA5A5
    step();
    bus.dma__memc__write_address = 24'h10;
    bus.dma__memc__write_data    = 32'hA5A5;
    #1;
    chk("dma_back_wr_ready", {31'h0, bus.memc__dma__write_ready}, 32'h1);
    chk("dma_back_ldst_dv", {31'h0, bus.memc__ldst__read_data_valid}, 32'h0);
    chk("dma_wr_en", {31'h0, bus.memc__mem__en}, 32'h1);
    chk("dma_wr_addr", {8'h0, bus.memc__mem__address}, 32'h10);
    chk("dma_wr_data", bus.memc__mem__write_data, 32'hA5A5);

    step();
    bus.dma__memc__write_valid  = 1'b0;
    bus.dma__memc__read_valid   = 1'b1;
    bus.dma__memc__read_address = 24'h10;
    #1;
    chk("dma_rd_en", {31'h0, bus.memc__mem__en}, 32'h1);
    chk("dma_rd_dv_accept", {31'h0, bus.memc__dma__read_data_valid}, 32'h0);

    // Pause while data is in flight: data still delivered, no new read
    step();
    bus.dma__memc__read_pause = 1'b1;
    #1;
    chk("dma_rd_dv", {31'h0, bus.memc__dma__read_data_valid}, 32'h1);
    chk("dma_rd_data", bus.memc__dma__read_data, 32'hA5A5);
    chk("pause_rd_ready", {31'h0, bus.memc__dma__read_ready}, 32'h0);
    chk("pause_mem_en", {31'h0, bus.memc__mem__en}, 32'h0);

    step();
    bus.dma__memc__read_valid = 1'b0;
    bus.dma__memc__read_pause = 1'b0;
    bus.ldst__memc__request   = 1'b1;
    #1;
    chk("pause_dv_clear", {31'h0, bus.memc__dma__read_data_valid}, 32'h0);
    chk("req_wr_ready", {31'h0, bus.memc__dma__write_ready}, 32'h0);

    // DRAIN, then LDST read of 0x10 with release
    step();
    bus.ldst__memc__request = 1'b0;
    step();
    bus.ldst__memc__valid    = 1'b1;
    bus.ldst__memc__we       = 1'b0;
    bus.ldst__memc__address  = 24'h10;
    bus.ldst__memc__released = 1'b1;
    #1;
    chk("ldst2_granted", {31'h0, bus.memc__ldst__granted}, 32'h1);

    // RELEASE with a fresh one-cycle request pulse
    step();
    bus.ldst__memc__valid    = 1'b0;
    bus.ldst__memc__released = 1'b0;
    bus.ldst__memc__request  = 1'b1;
    #1;
    chk("ldst2_dv", {31'h0, bus.memc__ldst__read_data_valid}, 32'h1);
    chk("ldst2_data", bus.memc__ldst__read_data, 32'hA5A5);

    // DMA_OWN: pending request must already block DMA
    step();
    bus.ldst__memc__request    = 1'b0;
    bus.dma__memc__write_valid = 1'b1;
    #1;
    chk("pend_wr_ready", {31'h0, bus.memc__dma__write_ready}, 32'h0);
    chk("pend_mem_en", {31'h0, bus.memc__mem__en}, 32'h0);

    step();
    bus.dma__memc__write_valid = 1'b0;
    #1;
    chk("pend_drain_granted", {31'h0, bus.memc__ldst__granted}, 32'h0);

    // LDST_OWN again: issue a read, then reset while it is in flight
    step();
    bus.ldst__memc__valid   = 1'b1;
    bus.ldst__memc__address = 24'h20;
    #1;
    chk("pend_granted", {31'h0, bus.memc__ldst__granted}, 32'h1);

    step();
    bus.ldst__memc__valid = 1'b0;
    reset_poweron         = 1'b1;
    #1;
    chk("rstfly_dv", {31'h0, bus.memc__ldst__read_data_valid}, 32'h0);
    chk("rstfly_wr_ready", {31'h0, bus.memc__dma__write_ready}, 32'h0);

    step();
    reset_poweron = 1'b0;
    #1;
    chk("postrst_granted", {31'h0, bus.memc__ldst__granted}, 32'h0);
    chk("postrst_ldst_dv", {31'h0, bus.memc__ldst__read_data_valid}, 32'h0);
    chk("postrst_dma_dv", {31'h0, bus.memc__dma__read_data_valid}, 32'h0);
    chk("postrst_wr_ready", {31'h0, bus.memc__dma__write_ready}, 32'h1);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memc_port_arbiter.md
MEMC_PORT_ARBITER -- requirements
Module: memc_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have ports clk (input, 1, single clock) and reset_poweron (input, 1, synchronous, active-high).
REQ-004 SHALL have DMA write ports dma__memc__write_valid (in, 1), dma__memc__write_address (in, ADDR_W), dma__memc__write_data (in, DATA_W) and memc__dma__write_ready (out, 1).
REQ-005 SHALL have DMA read ports dma__memc__read_valid (in, 1), dma__memc__read_address (in, ADDR_W), dma__memc__read_pause (in, 1), memc__dma__read_ready (out, 1), memc__dma__read_data (out, DATA_W) and memc__dma__read_data_valid (out, 1).
REQ-006 SHALL have SIMD load/store ports ldst__memc__request (in, 1), ldst__memc__released (in, 1), memc__ldst__granted (out, 1), ldst__memc__valid (in, 1), ldst__memc__we (in, 1), ldst__memc__address (in, ADDR_W), ldst__memc__write_data (in, DATA_W), memc__ldst__read_data (out, DATA_W) and memc__ldst__read_data_valid (out, 1).
REQ-007 SHALL have SRAM ports memc__mem__en (out, 1), memc__mem__we (out, 1), memc__mem__address (out, ADDR_W), memc__mem__write_data (out, DATA_W) and mem__memc__read_data (in, DATA_W, valid one cycle after an enabled read).

Function
REQ-008 SHALL implement FSM states DMA_OWN, DRAIN, LDST_OWN, RELEASE.
REQ-009 In DMA_OWN: ready outputs combinational from state; transfer occurs on valid&&ready; at most one SRAM access per cycle.
REQ-010 In DMA_OWN, write_ready SHALL be 1 and read_ready SHALL be !read_pause, except when both a write and an unpaused read are valid, in which case only the port chosen by a 1-bit round-robin pointer is ready.
REQ-011 Round-robin pointer SHALL toggle only after a contested grant; uncontested grants SHALL not change it; reset value selects write.
REQ-012 read_data_valid SHALL assert exactly one cycle after an accepted DMA read, with read_data = mem__memc__read_data; dma__memc__read_pause SHALL not suppress data already in flight.
REQ-013 DMA_OWN -> DRAIN when ldst__memc__request=1; in that cycle both DMA ready outputs SHALL already be 0.
REQ-014 DRAIN SHALL last exactly one cycle (completing any in-flight read return), then -> LDST_OWN.
REQ-015 In LDST_OWN, memc__ldst__granted=1; each cycle with ldst__memc__valid=1 issues one SRAM access (we per ldst__memc__we); memc__ldst__read_data_valid asserts one cycle after a read.
REQ-016 LDST_OWN -> RELEASE on ldst__memc__released=1; an access valid in the same cycle SHALL still be performed; granted deasserts in RELEASE.
REQ-017 RELEASE SHALL last one cycle (read return), then -> DMA_OWN; a new request seen in RELEASE SHALL be honoured from DMA_OWN on the following cycle.
REQ-018 ldst__memc__valid outside LDST_OWN SHALL be ignored; request deasserted in DRAIN SHALL still complete DRAIN then enter LDST_OWN.
REQ-019 memc__mem__en SHALL be 0 in any cycle without an accepted access; address/data outputs are don't-care then.

Reset
REQ-020 On reset_poweron=1 at a clk edge: state=DMA_OWN, pointer=write, granted=0, both read_data_valid=0, mem en/we=0, in-flight flag cleared; a read in flight SHALL return no data_valid.
REQ-021 During reset all ready outputs SHALL be 0.

Structure
REQ-022 FSM state enum and ADDR_W/DATA_W defaults SHALL reside in shared package memc_pkg.
REQ-023 The round-robin write/read picker SHALL be sub-module memc_rr_pick2; no other sub-modules.

Verification
REQ-024 Write addr 0x10 data 0xA5A5 then read 0x10 -> read_data_valid one cycle after accept, data 0xA5A5.
REQ-025 Write and read both valid 4 cycles -> grants alternate W,R,W,R; exactly 4 SRAM accesses.
REQ-026 ldst request during a DMA read burst -> DMA ready 0 same cycle, last read data returned, granted 2 cycles after request.
REQ-027 In LDST_OWN write 0x20=0x1234, read 0x20, assert released with read -> ldst data 0x1234; DMA ready returns 2 cycles after released.
REQ-028 read_pause=1 with read_valid=1 -> read_ready 0, no SRAM read; writes still accepted.
REQ-029 Reset asserted in LDST_OWN with read in flight -> next cycle granted=0, no data_valid, state DMA_OWN.
